op_issuer: RTL and testbench
============================

OP_ISSUER -- requirements
Module: op_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter LAT, default 1, cycles from op-unit drive to q sample (1..7).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_op  input  3  opcode (001 odd-test, 010 shl5, 011 a*55+b, 100 min, 101 (a+b)<<9).
REQ-008 cmd_a, cmd_b  input  8 each  operands.
REQ-009 op_a, op_b  output  8 each  operands driven to the op unit.
REQ-010 op_co  output  3  opcode driven to the op unit.
REQ-011 op_q  input  16  op-unit result.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_data  output  16  captured result.
REQ-015 res_op  output  3  opcode of that result.
REQ-016 res_err  output  1  opcode was illegal (000, 110, 111).
REQ-017 done_cnt  output  16  completed results handed off, wraps at 0xFFFF->0.

Function
REQ-018 Command accepted on a cycle with cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-019 FIFO full: cmd_ready low; the offered command is held by the producer, not dropped.
REQ-020 Same-cycle push and pop when full is not allowed; when neither full nor empty, push and pop proceed together and count is unchanged.
REQ-021 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE: if FIFO non-empty, pop the head and go to ISSUE next cycle.
REQ-023 ISSUE with legal opcode: register op_a/op_b/op_co from the popped entry, load wait counter with LAT, go to WAIT.
REQ-024 ISSUE with illegal opcode: op_co not driven (stays 000), load res_data=0, res_err=1, go to HOLD.
REQ-025 WAIT: decrement the counter; at 1, capture op_q into res_data, set res_op, res_err=0, go to HOLD.
REQ-026 HOLD: res_valid=1; res_data/res_op/res_err stable until handshake.
REQ-027 On res_valid && res_ready: increment done_cnt.
REQ-028 Handshake with FIFO non-empty: pop next entry, go directly to ISSUE (back-to-back).
REQ-029 Handshake with FIFO empty: go to IDLE.
REQ-030 op_co returns to 000 in every state except WAIT, so the op unit sees a new opcode only while a result is pending.
REQ-031 Latency, legal opcode, LAT=1, empty pipe: command accepted cycle N -> res_valid at cycle N+4.
REQ-032 res_valid is never asserted outside HOLD; one result per accepted command, in FIFO order.

Reset
REQ-033 rst_n low asynchronously clears all state:
  - FIFO empty, cmd_ready=1
  - state IDLE
  - op_a=op_b=0, op_co=000
  - res_valid=0, res_data=0, res_op=0, res_err=0
  - done_cnt=0
REQ-034 Reset mid-operation discards queued and in-flight commands; no result is produced for them after release.
REQ-035 First accept is possible on the first rising edge with rst_n high.

Verification
REQ-036 Behavioral op-unit model on op_a/op_b/op_co/op_q; single cmd op=011 a=3 b=4, res_ready=1 -> res_data=169, res_op=011, res_err=0, done_cnt=1.
REQ-037 Five commands back-to-back, res_ready=0, DEPTH=4 -> cmd_ready drops after the FIFO fills (one entry in flight); release res_ready -> results in order, no loss.
REQ-038 op=101 a=1 b=2 -> 1536; op=100 a=9 b=5 -> 5; op=001 a=7 -> 1; op=010 a=0xFF -> 0x1FE0.
REQ-039 op=110 a=1 b=1 -> res_err=1, res_data=0, op_co never nonzero for it; next legal command unaffected.
REQ-040 Assert rst_n low while in WAIT with 2 queued -> all outputs at reset values immediately; after release no res_valid without new commands.
REQ-041 done_cnt preloaded to 0xFFFF via 65535 results (or a force) -> next handshake yields 0x0000.

Source files
------------

// File: rtl/op_issuer.sv
// Command issuer: buffers opcodes in a small FIFO, drives them one at a time to
// an external op unit, and hands each captured result to a consumer.
module op_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic [2:0]  op_co,
  input  logic [15:0] op_q,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_op,
  output logic        res_err,
  output logic [15:0] done_cnt
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = 3;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t              state_q, state_d;
  cmd_t                mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                cmd_ready_q, cmd_ready_d;
  cmd_t                cur_q, cur_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [7:0]          op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]          op_co_q, op_co_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [2:0]          res_op_q, res_op_d;
  logic                res_err_q, res_err_d;
  logic [DATA_W-1:0]   done_cnt_q, done_cnt_d;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                cur_legal;

  assign push       = cmd_valid && cmd_ready_q;
  assign fifo_empty = (count_q == '0);
  assign cur_legal  = (cur_q.op != 3'd0) && (cur_q.op < 3'd6);

  // FIFO storage needs no reset: occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      cur_q       <= '0;
      wcnt_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_co_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      cur_q       <= cur_d;
      wcnt_q      <= wcnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_co_q     <= op_co_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_d       = cur_q;
    wcnt_d      = wcnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_co_d     = 3'b000;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    done_cnt_d  = done_cnt_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_legal) begin
          op_a_d  = cur_q.a;
          op_b_d  = cur_q.b;
          op_co_d = cur_q.op;
          wcnt_d  = WAIT_W'(LAT);
          state_d = WAIT;
        end else begin
          // illegal opcodes never reach the op unit
          res_data_d  = '0;
          res_op_d    = cur_q.op;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_W'(1)) begin
          res_data_d  = op_q;
          res_op_d    = op_co_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          op_co_d = op_co_q;
          wcnt_d  = wcnt_q - WAIT_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + DATA_W'(1);
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      cur_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CNT_W'(DEPTH));
  end

  assign cmd_ready = cmd_ready_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_co     = op_co_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_op_issuer.sv
// Bench for op_issuer: behavioural op unit plus a result scoreboard built from
// the opcode arithmetic, driven by directed and random command traffic.
module tb_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  op_a, op_b;
  logic [2:0]  op_co;
  logic [15:0] op_q;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        res_err;
  logic [15:0] done_cnt;

  int          checks = 0;
  int          errors = 0;
  int          opco_bad = 0;
  logic [19:0] exp_q[$];       // {op, err, data} per accepted command
  logic [15:0] done_m = '0;

  op_issuer #(.DEPTH(4), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .op_a(op_a), .op_b(op_b), .op_co(op_co), .op_q(op_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // {err, data} expected for an opcode, straight from the opcode definitions
  function automatic logic [16:0] ref_res(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    int r;
    case (op)
      3'd1:    r = int'(a) % 2;
      3'd2:    r = int'(a) * 32;
      3'd3:    r = int'(a) * 55 + int'(b);
      3'd4:    r = (a < b) ? int'(a) : int'(b);
      3'd5:    r = ((int'(a) + int'(b)) * 512) % 65536;
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, 16'(r)};
  endfunction

  // op unit: combinational, junk when no opcode is presented
  always_comb begin
    logic [16:0] t;
    t = ref_res(op_co, op_a, op_b);
    op_q = (op_co != 3'd0 && !t[16]) ? t[15:0] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: record accepts/handshakes seen at the edge, score results
  task automatic step(output bit acc);
    logic hs, hold;
    logic [15:0] d;
    logic [2:0] o, cop;
    logic e;
    logic [7:0] ca, cb;
    logic [19:0] x;
    hs   = res_valid && res_ready && rst_n;
    hold = res_valid && !res_ready && rst_n;
    acc  = cmd_valid && cmd_ready && rst_n;
    d = res_data; o = res_op; e = res_err;
    cop = cmd_op; ca = cmd_a; cb = cmd_b;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back({cop, ref_res(cop, ca, cb)});
    if (hs) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'(d), 32'hFFFF_FFFF);
      else begin
        x = exp_q.pop_front();
        check("res_data", 32'(d), 32'(x[15:0]));
        check("res_op", 32'(o), 32'(x[19:17]));
        check("res_err", 32'(e), 32'(x[16]));
        done_m++;
        check("done_cnt", 32'(done_cnt), 32'(done_m));
      end
    end
    if (hold) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'({res_op, res_err, res_data}), 32'({o, e, d}));
    end
    if (op_co > 3'd5) opco_bad++;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int waited);
    bit acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    waited = 0;
    do begin
      step(acc);
      waited++;
    end while (!acc && waited < 200);
    if (!acc) check("send_timeout", 32'(waited), 32'd0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    res_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      step(acc);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int w, got, seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    step(acc); step(acc);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_op_err", 32'({res_op, res_err}), 32'd0);
    check("rst_op_bus", 32'({op_a, op_b, op_co}), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);

    // single command, latency, accept on first edge after release
    rst_n = 1'b1;
    res_ready = 1'b1;
    send(3'b011, 8'd3, 8'd4, w);
    check("first_edge_accept", 32'(w), 32'd1);
    step(acc); step(acc);
    check("latency_not_early", 32'(res_valid), 32'd0);
    step(acc);
    check("latency_n_plus_4", 32'(res_valid), 32'd1);
    check("mac_169", 32'(res_data), 32'd169);
    drain();
    check("done_after_one", 32'(done_cnt), 32'd1);

    // directed arithmetic, including an illegal opcode between legal ones
    send(3'b101, 8'd1, 8'd2, w);
    send(3'b100, 8'd9, 8'd5, w);
    send(3'b001, 8'd7, 8'd0, w);
    send(3'b110, 8'd1, 8'd1, w);
    send(3'b010, 8'hFF, 8'd0, w);
    send(3'b000, 8'd3, 8'd3, w);
    send(3'b011, 8'hFF, 8'hFF, w);
    drain();

    // back-pressure: fill FIFO with one entry stuck in HOLD
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(3'(k % 5 + 1), 8'(k * 17 + 3), 8'(k * 5), w);
    check("full_after_5", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'd10; cmd_b = 8'd1;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      step(acc);
      got += int'(acc);
    end
    check("held_while_full", 32'(got), 32'd0);
    res_ready = 1'b1;
    w = 0;
    do begin
      step(acc);
      w++;
    end while (!acc && w < 50);
    check("sixth_accepted", 32'(acc), 32'd1);
    cmd_valid = 1'b0;
    drain();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    cmd_valid = 1'b0;
    drain();

    // reset while a command sits in WAIT with two more queued
    res_ready = 1'b0;
    send(3'b011, 8'd1, 8'd1, w);
    send(3'b100, 8'd2, 8'd3, w);
    send(3'b101, 8'd4, 8'd5, w);
    w = 0;
    while (op_co == 3'd0 && w < 20) begin
      step(acc);
      w++;
    end
    check("reached_wait", 32'(op_co != 3'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_res", 32'({res_valid, res_err, res_op, res_data}), 32'd0);
    check("mid_rst_op_bus", 32'({op_a, op_b, op_co}), 32'd0);
    check("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    exp_q.delete();
    done_m = '0;
    step(acc);
    rst_n = 1'b1;
    res_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step(acc);
      seen += int'(res_valid);
    end
    check("no_result_after_reset", 32'(seen), 32'd0);

    // done_cnt wraparound
    force dut.done_cnt_q = 16'hFFFF;
    #1;
    release dut.done_cnt_q;
    done_m = 16'hFFFF;
    send(3'b100, 8'd6, 8'd200, w);
    drain();
    check("done_wrap_zero", 32'(done_cnt), 32'd0);

    check("op_co_only_legal", 32'(opco_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
